// File: rtl/td4_exec_ctrl.sv
// td4_exec_ctrl
// Run/step/load sequencer for the TD4 4-bit core. It gates core progress with a
// registered one-cycle clock enable, holds the core in reset while a program
// image is streamed into the program memory, and halts on a PC breakpoint.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active-low
//   cmd_valid  in   host command valid
//   cmd_op     in   2'b00 HALT, 2'b01 RUN, 2'b10 STEP, 2'b11 LOAD
//   cmd_ready  out  command accepted when cmd_valid & cmd_ready (HALT and RUN only)
//   ld_valid   in   program byte valid (only looked at in LOAD)
//   ld_data    in   program byte
//   ld_last    in   final byte of the image
//   ld_ready   out  high only in LOAD
//   pc         in   core PC, compared against the breakpoint
//   bp_en      in   breakpoint enable
//   bp_addr    in   breakpoint address
//   cpu_en     out  registered one-cycle core clock enable
//   cpu_rst_n  out  core reset, active-low
//   pmem_we    out  program memory write strobe
//   pmem_addr  out  program memory write address
//   pmem_wdata out  program memory write data
//   state      out  0 HALT, 1 LOAD, 2 RUN, 3 STEP
//   bp_hit     out  sticky breakpoint flag, cleared by any accepted command
//   instr_cnt  out  cpu_en pulses since the last LOAD, saturating

module td4_exec_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int RATE_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  output logic              cmd_ready,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] pc,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              cpu_en,
  output logic              cpu_rst_n,
  output logic              pmem_we,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [DATA_W-1:0] pmem_wdata,
  output logic [1:0]        state,
  output logic              bp_hit,
  output logic [15:0]       instr_cnt
);

  // A divider of RATE_DIV=1 still needs one bit so the compare stays legal.
  localparam int DIV_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RATE_DIV - 1);

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_STEP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q;
  logic              first_q;
  logic              accept;
  logic              tick_due;
  logic              run_tick;
  logic              step_tick;
  logic              bp_stop;
  logic              beat;
  logic              load_entry;
  logic              run_entry;
  logic [ADDR_W-1:0] beat_addr;

  assign cmd_ready = (state_q == S_HALT) || (state_q == S_RUN);
  assign ld_ready  = (state_q == S_LOAD);
  assign state     = state_q;

  // pmem_addr only advances in the cycle after a write is shown, so the
  // address of a beat arriving now is one past it while a write is pending.
  assign beat_addr = pmem_addr + ADDR_W'(pmem_we);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_HALT;
    else        state_q <= state_d;
  end

  // An accepted command always wins over a tick that is due in the same cycle.
  // The first tick after a RUN is accepted skips the breakpoint so a halted
  // program can resume past the instruction it stopped on.
  always_comb begin
    state_d    = state_q;
    accept     = cmd_valid & cmd_ready;
    tick_due   = (state_q == S_RUN) && (div_q == DIV_MAX);
    run_tick   = 1'b0;
    step_tick  = 1'b0;
    bp_stop    = 1'b0;
    beat       = 1'b0;
    load_entry = 1'b0;
    run_entry  = 1'b0;
    case (state_q)
      S_HALT, S_RUN: begin
        if (accept) begin
          case (cmd_op)
            OP_HALT: state_d = S_HALT;
            OP_RUN: begin
              state_d   = S_RUN;
              run_entry = 1'b1;
            end
            OP_STEP: begin
              state_d   = S_STEP;
              step_tick = 1'b1;
            end
            default: begin
              state_d    = S_LOAD;
              load_entry = 1'b1;
            end
          endcase
        end else if (tick_due) begin
          if (!first_q && bp_en && (pc == bp_addr)) begin
            bp_stop = 1'b1;
            state_d = S_HALT;
          end else begin
            run_tick = 1'b1;
          end
        end
      end
      S_LOAD: begin
        beat = ld_valid;
        if (ld_valid && (ld_last || (beat_addr == {ADDR_W{1'b1}}))) state_d = S_HALT;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_en     <= 1'b0;
      cpu_rst_n  <= 1'b0;
      bp_hit     <= 1'b0;
      div_q      <= '0;
      first_q    <= 1'b0;
      instr_cnt  <= '0;
      pmem_we    <= 1'b0;
      pmem_addr  <= '0;
      pmem_wdata <= '0;
    end else begin
      cpu_en <= run_tick | step_tick;

      // Core stays in reset from LOAD entry until one cycle after LOAD ends.
      cpu_rst_n <= !(load_entry || (state_q == S_LOAD));

      if (accept)       bp_hit <= 1'b0;
      else if (bp_stop) bp_hit <= 1'b1;

      if (accept)                 div_q <= '0;
      else if (state_q == S_RUN)  div_q <= tick_due ? '0 : div_q + DIV_W'(1);

      if (run_entry)     first_q <= 1'b1;
      else if (run_tick) first_q <= 1'b0;

      if (load_entry)
        instr_cnt <= '0;
      else if ((run_tick || step_tick) && (instr_cnt != 16'hFFFF))
        instr_cnt <= instr_cnt + 16'd1;

      if (load_entry) begin
        pmem_we   <= 1'b0;
        pmem_addr <= '0;
      end else begin
        pmem_we <= beat;
        if (pmem_we && (pmem_addr != {ADDR_W{1'b1}})) pmem_addr <= pmem_addr + ADDR_W'(1);
        if (beat) pmem_wdata <= ld_data;
      end
    end
  end

endmodule
